// File: rtl/lcd_read_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : lcd_pkg
// Brief   : Shared types and default timing for the HD44780 read engine.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lcd_pkg;

  // Controller phases of one LCD read cycle
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_E_HIGH = 3'd2,
    ST_E_LOW  = 3'd3,
    ST_DONE   = 3'd4
  } lcd_state_t;

  typedef logic [7:0] lcd_byte_t;

  // Default timing in 50 MHz clocks
  localparam int DEF_T_AS     = 3;
  localparam int DEF_T_EH     = 25;
  localparam int DEF_T_EL     = 25;
  localparam int DEF_POLL_MAX = 50000;

  // Busy flag position in the status byte
  localparam int LCD_BF_BIT = 7;

  // Register-select encodings
  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  // Counter width able to hold n-1 (never below one bit)
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_read_ctrl_if.sv
//------------------------------------------------------------------------------
// Module  : lcd_read_ctrl_if
// Brief   : Request/result handshake plus LCD pin bundle for the read engine.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lcd_read_ctrl_if;
  import lcd_pkg::*;

  logic      iREQ;
  logic      iRS;
  logic      iPOLL;
  logic      oREADY;
  logic      oVALID;
  logic      oTIMEOUT;
  lcd_byte_t oDATA;
  logic      oBUS_OWN;
  lcd_byte_t LCD_DATA_IN;
  logic      LCD_RW;
  logic      LCD_RS;
  logic      LCD_E;

  // Requester side (also supplies the sampled LCD data bus)
  modport master (
    output iREQ, iRS, iPOLL, LCD_DATA_IN,
    input  oREADY, oVALID, oTIMEOUT, oDATA, oBUS_OWN, LCD_RW, LCD_RS, LCD_E
  );

  // Read engine side
  modport slave (
    input  iREQ, iRS, iPOLL, LCD_DATA_IN,
    output oREADY, oVALID, oTIMEOUT, oDATA, oBUS_OWN, LCD_RW, LCD_RS, LCD_E
  );

endinterface

`default_nettype wire

// File: rtl/lcd_read_ctrl_phase_timer.sv
//------------------------------------------------------------------------------
// Module  : lcd_phase_timer
// Brief   : Loadable down-counter; done is high during the last cycle of a
//           phase. Loading N-1 gives a phase of exactly N cycles.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_phase_timer #(
  parameter int WIDTH = 5
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_val,
  output logic                  done
);

  logic [WIDTH-1:0] count;
  logic             active;

  // Count down after a load; go inactive once the final cycle has passed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      active <= 1'b0;
    end else if (load) begin
      count  <= load_val;
      active <= 1'b1;
    end else if (active) begin
      if (count == '0) begin
        active <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign done = active && (count == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_read_ctrl.sv
//------------------------------------------------------------------------------
// Module  : lcd_read_ctrl
// Brief   : HD44780 read-cycle engine: busy/address and data reads with an
//           optional busy-poll loop that stops on BF=0 or after POLL_MAX reads.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_read_ctrl
  import lcd_pkg::*;
#(
  parameter int T_AS     = DEF_T_AS,
  parameter int T_EH     = DEF_T_EH,
  parameter int T_EL     = DEF_T_EL,
  parameter int POLL_MAX = DEF_POLL_MAX
) (
  input  wire logic       iCLK_50MHZ,
  input  wire logic       iRST_N,
  lcd_read_ctrl_if.slave  bus
);

  localparam int T_MAX = (T_AS > T_EH) ? ((T_AS > T_EL) ? T_AS : T_EL)
                                       : ((T_EH > T_EL) ? T_EH : T_EL);
  localparam int TW = cnt_width(T_MAX);
  localparam int PW = $clog2(POLL_MAX + 1);

  localparam logic [TW-1:0] LD_AS     = TW'(T_AS - 1);
  localparam logic [TW-1:0] LD_EH     = TW'(T_EH - 1);
  localparam logic [TW-1:0] LD_EL     = TW'(T_EL - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
  localparam logic [PW-1:0] POLL_SAT  = PW'(POLL_MAX);

  lcd_state_t    state;
  lcd_byte_t     rd_data;
  logic          lcd_e;
  logic          lcd_rw;
  logic          lcd_rs;
  logic          bus_own;
  logic          ready;
  logic          valid;
  logic          timeout;
  logic          poll_en;
  logic [PW-1:0] poll_cnt;

  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_done;
  logic          busy_seen;
  logic          poll_again;

  // Another poll read is due while BF=1 and the read budget is not spent
  assign busy_seen  = poll_en && rd_data[LCD_BF_BIT];
  assign poll_again = busy_seen && (poll_cnt < POLL_LAST);

  lcd_phase_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (iCLK_50MHZ),
    .rst_n    (iRST_N),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // Arm the phase timer on every edge that enters SETUP, E_HIGH or E_LOW
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.iREQ) begin
          timer_load = 1'b1;
          timer_val  = LD_AS;
        end
      end
      ST_SETUP: begin
        if (timer_done) begin
          timer_load = 1'b1;
          timer_val  = LD_EH;
        end
      end
      ST_E_HIGH: begin
        if (timer_done) begin
          timer_load = 1'b1;
          timer_val  = LD_EL;
        end
      end
      ST_E_LOW: begin
        if (timer_done && poll_again) begin
          timer_load = 1'b1;
          timer_val  = LD_AS;
        end
      end
      default: begin
        timer_load = 1'b0;
      end
    endcase
  end

  // Read-cycle sequencer with registered pin and handshake outputs
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= ST_IDLE;
      lcd_e    <= 1'b0;
      lcd_rw   <= 1'b0;
      lcd_rs   <= 1'b0;
      bus_own  <= 1'b0;
      ready    <= 1'b1;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      rd_data  <= '0;
      poll_en  <= 1'b0;
      poll_cnt <= '0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.iREQ) begin
            state    <= ST_SETUP;
            lcd_rs   <= bus.iRS;
            lcd_rw   <= 1'b1;
            bus_own  <= 1'b1;
            ready    <= 1'b0;
            poll_en  <= bus.iPOLL & (bus.iRS == RS_CMD);
            poll_cnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (timer_done) begin
            state <= ST_E_HIGH;
            lcd_e <= 1'b1;
          end
        end
        ST_E_HIGH: begin
          if (timer_done) begin
            state   <= ST_E_LOW;
            lcd_e   <= 1'b0;
            rd_data <= bus.LCD_DATA_IN;
          end
        end
        ST_E_LOW: begin
          if (timer_done) begin
            if (poll_again) begin
              state <= ST_SETUP;
              if (poll_cnt != POLL_SAT) begin
                poll_cnt <= poll_cnt + 1'b1;
              end
            end else begin
              state   <= ST_DONE;
              valid   <= !busy_seen;
              timeout <= busy_seen;
              lcd_rw  <= 1'b0;
              lcd_rs  <= 1'b0;
              bus_own <= 1'b0;
              ready   <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.LCD_E    = lcd_e;
  assign bus.LCD_RW   = lcd_rw;
  assign bus.LCD_RS   = lcd_rs;
  assign bus.oBUS_OWN = bus_own;
  assign bus.oREADY   = ready;
  assign bus.oVALID   = valid;
  assign bus.oTIMEOUT = timeout;
  assign bus.oDATA    = rd_data;

endmodule

`default_nettype wire

// File: tb/tb_lcd_read_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_lcd_read_ctrl
// Brief   : Directed self-checking bench for lcd_read_ctrl. Cycle offsets k
//           count clock edges after the accepting edge (k=0), so the
//           "edge 54" result of a single read is seen at k=53.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lcd_read_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   rw_viol = 0;
  logic p_e0, p_rw0, p_e1, p_rw1;

  lcd_read_ctrl_if if0 ();
  lcd_read_ctrl_if if1 ();

  lcd_read_ctrl u_dut0 (
    .iCLK_50MHZ (clk),
    .iRST_N     (rst_n),
    .bus        (if0.slave)
  );

  lcd_read_ctrl #(
    .POLL_MAX (4)
  ) u_dut1 (
    .iCLK_50MHZ (clk),
    .iRST_N     (rst_n),
    .bus        (if1.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RW must hold steady whenever E is (or just was) high
  always @(negedge clk) begin
    if (!rst_n) begin
      p_e0 <= 1'b0; p_rw0 <= 1'b0; p_e1 <= 1'b0; p_rw1 <= 1'b0;
    end else begin
      if ((p_e0 || if0.LCD_E) && (if0.LCD_RW !== p_rw0)) rw_viol <= rw_viol + 1;
      if ((p_e1 || if1.LCD_E) && (if1.LCD_RW !== p_rw1)) rw_viol <= rw_viol + 1;
      p_e0 <= if0.LCD_E; p_rw0 <= if0.LCD_RW;
      p_e1 <= if1.LCD_E; p_rw1 <= if1.LCD_RW;
    end
  end

  // Results of the last run_txn call
  int        r_e_rise, r_e_high, r_pulses, r_valid_k, r_timeout_k;
  int        r_valid_cnt, r_timeout_cnt, r_both, r_bad_ctl;
  logic [7:0] r_data;
  logic      r_own, r_ready, r_ready_k1;

  // Issue one request and record what the pins do until the result appears.
  // The bus returns d_busy for the first n_busy reads and d_final afterwards.
  task automatic run_txn(input bit which, input logic rs, input logic poll,
                         input logic [7:0] d_busy, input logic [7:0] d_final,
                         input int n_busy);
    int t0, k, end_k;
    logic e, e_prev, rw, rso, own, rdy, v, to;
    logic [7:0] d;
    r_e_rise = -1; r_e_high = 0; r_pulses = 0; r_valid_k = -1; r_timeout_k = -1;
    r_valid_cnt = 0; r_timeout_cnt = 0; r_both = 0; r_bad_ctl = 0;
    r_data = 8'h00; r_own = 1'b1; r_ready = 1'b0; r_ready_k1 = 1'b1;
    @(negedge clk);
    if (which) begin
      if1.LCD_DATA_IN = (n_busy > 0) ? d_busy : d_final;
      if1.iRS = rs; if1.iPOLL = poll; if1.iREQ = 1'b1;
    end else begin
      if0.LCD_DATA_IN = (n_busy > 0) ? d_busy : d_final;
      if0.iRS = rs; if0.iPOLL = poll; if0.iREQ = 1'b1;
    end
    @(posedge clk);
    #1;
    t0 = cyc;
    if0.iREQ = 1'b0; if1.iREQ = 1'b0;
    e_prev = 1'b0; end_k = 1000; k = 0;
    while (k < end_k) begin
      @(negedge clk);
      k = cyc - t0;
      e   = which ? if1.LCD_E    : if0.LCD_E;
      rw  = which ? if1.LCD_RW   : if0.LCD_RW;
      rso = which ? if1.LCD_RS   : if0.LCD_RS;
      own = which ? if1.oBUS_OWN : if0.oBUS_OWN;
      rdy = which ? if1.oREADY   : if0.oREADY;
      v   = which ? if1.oVALID   : if0.oVALID;
      to  = which ? if1.oTIMEOUT : if0.oTIMEOUT;
      d   = which ? if1.oDATA    : if0.oDATA;
      if (k == 1) r_ready_k1 = rdy;
      if (e && r_e_rise < 0) r_e_rise = k;
      if (e && r_pulses == 0) r_e_high++;
      if (e && (rw !== 1'b1 || rso !== rs)) r_bad_ctl++;
      if (e_prev && !e) begin
        r_pulses++;
        if (which) if1.LCD_DATA_IN = (r_pulses < n_busy) ? d_busy : d_final;
        else       if0.LCD_DATA_IN = (r_pulses < n_busy) ? d_busy : d_final;
      end
      e_prev = e;
      if (v && to) r_both++;
      if (v) r_valid_cnt++;
      if (to) r_timeout_cnt++;
      if (v && r_valid_k < 0) r_valid_k = k;
      if (to && r_timeout_k < 0) r_timeout_k = k;
      if ((v || to) && end_k == 1000) begin
        end_k = k + 4;
        r_data = d; r_own = own; r_ready = rdy;
      end
    end
  endtask

  task automatic test_reset();
    int e_seen;
    tests_run++; if (if0.LCD_E !== 1'b0) begin tests_failed++; $display("FAIL rst_e: got %b want 0", if0.LCD_E); end
    tests_run++; if (if0.LCD_RW !== 1'b0) begin tests_failed++; $display("FAIL rst_rw: got %b want 0", if0.LCD_RW); end
    tests_run++; if (if0.LCD_RS !== 1'b0) begin tests_failed++; $display("FAIL rst_rs: got %b want 0", if0.LCD_RS); end
    tests_run++; if (if0.oBUS_OWN !== 1'b0) begin tests_failed++; $display("FAIL rst_own: got %b want 0", if0.oBUS_OWN); end
    tests_run++; if (if0.oREADY !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: got %b want 1", if0.oREADY); end
    tests_run++; if (if0.oVALID !== 1'b0 || if0.oTIMEOUT !== 1'b0) begin tests_failed++; $display("FAIL rst_pulses: got v=%b t=%b want 0/0", if0.oVALID, if0.oTIMEOUT); end
    tests_run++; if (if0.oDATA !== 8'h00) begin tests_failed++; $display("FAIL rst_data: got %h want 00", if0.oDATA); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (if0.oREADY !== 1'b1 || if1.oREADY !== 1'b1) begin tests_failed++; $display("FAIL rel_ready: got %b/%b want 1/1", if0.oREADY, if1.oREADY); end
    // Start a read and reset it in the middle of the E-high phase
    if0.iRS = 1'b1; if0.iPOLL = 1'b0; if0.LCD_DATA_IN = 8'h41; if0.iREQ = 1'b1;
    @(posedge clk); #1; if0.iREQ = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++; if (if0.LCD_E !== 1'b1) begin tests_failed++; $display("FAIL mid_e_high: got %b want 1", if0.LCD_E); end
    #2; rst_n = 1'b0; #1;
    tests_run++; if (if0.LCD_E !== 1'b0) begin tests_failed++; $display("FAIL async_e_drop: got %b want 0", if0.LCD_E); end
    tests_run++; if (if0.LCD_RW !== 1'b0 || if0.oBUS_OWN !== 1'b0 || if0.oREADY !== 1'b1) begin tests_failed++; $display("FAIL async_outs: got rw=%b own=%b rdy=%b want 0/0/1", if0.LCD_RW, if0.oBUS_OWN, if0.oREADY); end
    repeat (2) @(negedge clk); rst_n = 1'b1;
    e_seen = 0;
    repeat (6) begin @(negedge clk); if (if0.LCD_E) e_seen++; end
    tests_run++; if (e_seen !== 0) begin tests_failed++; $display("FAIL post_rst_e: got %0d high cycles want 0", e_seen); end
    tests_run++; if (if0.oREADY !== 1'b1) begin tests_failed++; $display("FAIL post_rst_ready: got %b want 1", if0.oREADY); end
  endtask

  task automatic test_single_data_read();
    run_txn(1'b0, 1'b1, 1'b0, 8'h00, 8'h41, 0);
    tests_run++; if (r_ready_k1 !== 1'b0) begin tests_failed++; $display("FAIL data_ready_drop: got %b want 0", r_ready_k1); end
    tests_run++; if (r_e_rise !== 3) begin tests_failed++; $display("FAIL data_e_rise: got %0d want 3", r_e_rise); end
    tests_run++; if (r_e_high !== 25) begin tests_failed++; $display("FAIL data_e_width: got %0d want 25", r_e_high); end
    tests_run++; if (r_pulses !== 1) begin tests_failed++; $display("FAIL data_pulses: got %0d want 1", r_pulses); end
    tests_run++; if (r_bad_ctl !== 0) begin tests_failed++; $display("FAIL data_rs_rw: got %0d bad cycles want 0", r_bad_ctl); end
    tests_run++; if (r_valid_k !== 53) begin tests_failed++; $display("FAIL data_latency: got %0d want 53", r_valid_k); end
    tests_run++; if (r_data !== 8'h41) begin tests_failed++; $display("FAIL data_value: got %h want 41", r_data); end
    tests_run++; if (r_own !== 1'b0 || r_ready !== 1'b1) begin tests_failed++; $display("FAIL data_release: got own=%b rdy=%b want 0/1", r_own, r_ready); end
    tests_run++; if (r_valid_cnt !== 1 || r_timeout_cnt !== 0) begin tests_failed++; $display("FAIL data_pulse_count: got v=%0d t=%0d want 1/0", r_valid_cnt, r_timeout_cnt); end
  endtask

  task automatic test_busy_read();
    run_txn(1'b0, 1'b0, 1'b0, 8'h00, 8'h8A, 0);
    tests_run++; if (r_data !== 8'h8A) begin tests_failed++; $display("FAIL busy_value: got %h want 8a", r_data); end
    tests_run++; if (r_pulses !== 1) begin tests_failed++; $display("FAIL busy_pulses: got %0d want 1", r_pulses); end
    tests_run++; if (r_valid_k !== 53) begin tests_failed++; $display("FAIL busy_latency: got %0d want 53", r_valid_k); end
    tests_run++; if (r_bad_ctl !== 0) begin tests_failed++; $display("FAIL busy_rs_rw: got %0d bad cycles want 0", r_bad_ctl); end
    // Poll request on a data read must behave as a single read
    run_txn(1'b0, 1'b1, 1'b1, 8'h85, 8'h05, 3);
    tests_run++; if (r_pulses !== 1 || r_data !== 8'h85) begin tests_failed++; $display("FAIL poll_ignored: got pulses=%0d data=%h want 1/85", r_pulses, r_data); end
  endtask

  task automatic test_poll();
    run_txn(1'b0, 1'b0, 1'b1, 8'h85, 8'h05, 3);
    tests_run++; if (r_pulses !== 4) begin tests_failed++; $display("FAIL poll_pulses: got %0d want 4", r_pulses); end
    tests_run++; if (r_valid_k !== 212) begin tests_failed++; $display("FAIL poll_latency: got %0d want 212", r_valid_k); end
    tests_run++; if (r_data !== 8'h05) begin tests_failed++; $display("FAIL poll_value: got %h want 05", r_data); end
    tests_run++; if (r_timeout_cnt !== 0 || r_valid_cnt !== 1) begin tests_failed++; $display("FAIL poll_pulse_count: got v=%0d t=%0d want 1/0", r_valid_cnt, r_timeout_cnt); end
  endtask

  task automatic test_poll_timeout();
    run_txn(1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 100);
    tests_run++; if (r_pulses !== 4) begin tests_failed++; $display("FAIL to_pulses: got %0d want 4", r_pulses); end
    tests_run++; if (r_timeout_k !== 212) begin tests_failed++; $display("FAIL to_latency: got %0d want 212", r_timeout_k); end
    tests_run++; if (r_timeout_cnt !== 1 || r_valid_cnt !== 0) begin tests_failed++; $display("FAIL to_pulse_count: got v=%0d t=%0d want 0/1", r_valid_cnt, r_timeout_cnt); end
    tests_run++; if (r_data !== 8'hFF) begin tests_failed++; $display("FAIL to_value: got %h want ff", r_data); end
    tests_run++; if (r_both !== 0) begin tests_failed++; $display("FAIL to_overlap: got %0d want 0", r_both); end
    // BF clears exactly on the last allowed read: still a valid result
    run_txn(1'b1, 1'b0, 1'b1, 8'h85, 8'h05, 3);
    tests_run++; if (r_valid_k !== 212 || r_timeout_cnt !== 0 || r_data !== 8'h05) begin tests_failed++; $display("FAIL last_read_ok: got k=%0d t=%0d data=%h want 212/0/05", r_valid_k, r_timeout_cnt, r_data); end
  endtask

  task automatic test_back_to_back();
    int t0, k, n_valid, v1, v2, rise2, pulses, vk;
    logic rdy54, e_prev;
    if0.LCD_DATA_IN = 8'h33; if0.iRS = 1'b1; if0.iPOLL = 1'b0;
    @(negedge clk); if0.iREQ = 1'b1;
    @(posedge clk); #1; t0 = cyc;
    n_valid = 0; v1 = -1; v2 = -1; rise2 = -1; pulses = 0; rdy54 = 1'b1; e_prev = 1'b0;
    repeat (130) begin
      @(negedge clk);
      k = cyc - t0;
      if (k == 60) if0.iREQ = 1'b0;
      if (k == 54) rdy54 = if0.oREADY;
      if (if0.oVALID) begin
        n_valid++;
        if (v1 < 0) v1 = k; else if (v2 < 0) v2 = k;
      end
      if (e_prev && !if0.LCD_E) pulses++;
      if (if0.LCD_E && !e_prev && pulses == 1 && rise2 < 0) rise2 = k;
      e_prev = if0.LCD_E;
    end
    tests_run++; if (v1 !== 53 || v2 !== 107) begin tests_failed++; $display("FAIL b2b_valids: got %0d,%0d want 53,107", v1, v2); end
    tests_run++; if (rdy54 !== 1'b0) begin tests_failed++; $display("FAIL b2b_accept_on_done: got ready=%b want 0", rdy54); end
    tests_run++; if (rise2 !== 57) begin tests_failed++; $display("FAIL b2b_second_e: got %0d want 57", rise2); end
    tests_run++; if (n_valid !== 2 || pulses !== 2) begin tests_failed++; $display("FAIL b2b_count: got v=%0d e=%0d want 2/2", n_valid, pulses); end
    tests_run++; if (if0.oREADY !== 1'b1) begin tests_failed++; $display("FAIL b2b_idle: got %b want 1", if0.oREADY); end
    // Short request pulses while busy are dropped, not queued
    @(negedge clk); if0.iREQ = 1'b1;
    @(posedge clk); #1; t0 = cyc; if0.iREQ = 1'b0;
    n_valid = 0; pulses = 0; vk = -1; e_prev = 1'b0;
    repeat (120) begin
      @(negedge clk);
      k = cyc - t0;
      if0.iREQ = (k == 10 || k == 30 || k == 45);
      if (if0.oVALID) begin n_valid++; if (vk < 0) vk = k; end
      if (e_prev && !if0.LCD_E) pulses++;
      e_prev = if0.LCD_E;
    end
    if0.iREQ = 1'b0;
    tests_run++; if (n_valid !== 1 || pulses !== 1 || vk !== 53) begin tests_failed++; $display("FAIL busy_req_ignored: got v=%0d e=%0d k=%0d want 1/1/53", n_valid, pulses, vk); end
    tests_run++; if (rw_viol !== 0) begin tests_failed++; $display("FAIL rw_stable_in_e: got %0d changes want 0", rw_viol); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    if0.iREQ = 1'b0; if0.iRS = 1'b0; if0.iPOLL = 1'b0; if0.LCD_DATA_IN = 8'h00;
    if1.iREQ = 1'b0; if1.iRS = 1'b0; if1.iPOLL = 1'b0; if1.LCD_DATA_IN = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_data_read();
    test_busy_read();
    test_poll();
    test_poll_timeout();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
